// File: rtl/grid_router_rx_link_trainer.sv
// Receive-side link trainer: sequences deserializer reset, bit-slips until the training
// pattern is seen pMatchNeeded times in a row, then supervises the link.
// Optional idle-fill monitor in LINK_UP: define GRID_ROUTER_RX_IDLE_MON_EN.
module grid_router_rx_link_trainer #(
    parameter int                pWidth        = 10,
    parameter logic [pWidth-1:0] pTrainPattern = 10'h17C,
    parameter int                pRstCycles    = 8,
    parameter int                pSettleCycles = 16,
    parameter int                pMatchNeeded  = 32,
    parameter int                pMaxFails     = 255
`ifdef GRID_ROUTER_RX_IDLE_MON_EN
    ,
    parameter int                pIdleTimeout  = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic              retrain,
    input  logic [pWidth-1:0] rx_data,
    output logic              serdes_rst,
    output logic              bitslip,
    output logic              link_up,
    output logic [3:0]        slip_cnt,
    output logic [7:0]        fail_cnt
);

    localparam int TW = 16;
    localparam int MW = $clog2(pMatchNeeded + 1);
    localparam logic [TW-1:0] RST_LOAD    = TW'(pRstCycles);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(pSettleCycles);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(pMatchNeeded - 1);
    localparam logic [3:0]    SLIP_LAST   = 4'(pWidth - 1);
    localparam logic [7:0]    MAX_FAILS   = 8'(pMaxFails);
`ifdef GRID_ROUTER_RX_IDLE_MON_EN
    localparam int            IW          = $clog2(pIdleTimeout + 1);
    localparam logic [IW-1:0] IDLE_LAST   = IW'(pIdleTimeout - 1);
`endif

    typedef enum logic [2:0] {
        WAIT_LOCK,
        RST_SERDES,
        SETTLE,
        SEARCH,
        SLIP,
        LINK_UP
    } state_t;

    state_t          state;
    logic            sync_ff;
    logic            lock_s;
    logic [TW-1:0]   timer;
    logic [MW-1:0]   match_cnt;
`ifdef GRID_ROUTER_RX_IDLE_MON_EN
    logic [IW-1:0]   idle_cnt;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == MAX_FAILS) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            sync_ff    <= 1'b0;
            lock_s     <= 1'b0;
            timer      <= '0;
            match_cnt  <= '0;
            serdes_rst <= 1'b1;
            bitslip    <= 1'b0;
            link_up    <= 1'b0;
            slip_cnt   <= '0;
            fail_cnt   <= '0;
`ifdef GRID_ROUTER_RX_IDLE_MON_EN
            idle_cnt   <= '0;
`endif
        end else begin
            sync_ff <= locked;
            lock_s  <= sync_ff;
            bitslip <= 1'b0;

            // Lock loss outranks retrain; both outrank whatever the state was about to do.
            if (state != WAIT_LOCK && !lock_s) begin
                state      <= WAIT_LOCK;
                serdes_rst <= 1'b1;
                link_up    <= 1'b0;
            end else if (state != WAIT_LOCK && retrain) begin
                state      <= RST_SERDES;
                timer      <= RST_LOAD;
                serdes_rst <= 1'b1;
                link_up    <= 1'b0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        serdes_rst <= 1'b1;
                        link_up    <= 1'b0;
                        if (lock_s) begin
                            timer <= RST_LOAD;
                            state <= RST_SERDES;
                        end
                    end
                    RST_SERDES: begin
                        if (timer <= TW'(1)) begin
                            serdes_rst <= 1'b0;
                            timer      <= SETTLE_LOAD;
                            slip_cnt   <= '0;
                            match_cnt  <= '0;
                            state      <= SETTLE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    SETTLE: begin
                        if (timer <= TW'(1)) begin
                            match_cnt <= '0;
                            state     <= SEARCH;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    SEARCH: begin
                        if (rx_data == pTrainPattern) begin
                            if (match_cnt == MATCH_LAST) begin
                                link_up <= 1'b1;
                                state   <= LINK_UP;
`ifdef GRID_ROUTER_RX_IDLE_MON_EN
                                idle_cnt <= '0;
`endif
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                            state     <= SLIP;
                        end
                    end
                    SLIP: begin
                        bitslip  <= 1'b1;
                        slip_cnt <= slip_cnt + 4'd1;
                        // Every bit position has been tried: restart the deserializer.
                        if (slip_cnt == SLIP_LAST) begin
                            fail_cnt   <= sat_inc(fail_cnt);
                            timer      <= RST_LOAD;
                            serdes_rst <= 1'b1;
                            state      <= RST_SERDES;
                        end else begin
                            timer <= SETTLE_LOAD;
                            state <= SETTLE;
                        end
                    end
                    LINK_UP: begin
                        link_up <= 1'b1;
`ifdef GRID_ROUTER_RX_IDLE_MON_EN
                        // Transmitter inserts the training word as idle fill; a long gap means misalignment.
                        if (rx_data == pTrainPattern) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            fail_cnt   <= sat_inc(fail_cnt);
                            timer      <= RST_LOAD;
                            serdes_rst <= 1'b1;
                            link_up    <= 1'b0;
                            state      <= RST_SERDES;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
`endif
                    end
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end

endmodule
